// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous single-port data RAM between the core and an external master.
// Optional build macro DMEM_ARB_STATS_EN adds a saturating contention counter output (conflict_cnt).
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              c_r,
    input  logic              c_w,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_rvalid,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, C_RD, E_RD} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state, state_nx;
    logic [3:0] starve_cnt, starve_nx;
    logic [DATA_W-1:0] c_rdata_q, e_rdata_q;
    logic rd_done, core_req, ext_req, force_ext, ext_win, core_win;
    // Grant decision, RAM drive and next state; reset masks every request so outputs drop at once
    always_comb begin
        rd_done   = (state == C_RD);
        core_req  = (c_r | c_w) & ~rd_done & ~RST;
        ext_req   = e_req & ~RST;
        force_ext = ext_req & (starve_cnt == LIMIT);
        ext_win   = ext_req & (force_ext | ~core_req);
        core_win  = core_req & ~ext_win;
        m_en      = ext_win | core_win;
        m_we      = ext_win ? e_we : core_win & c_w;
        m_addr    = ext_win ? e_addr : core_win ? c_addr : '0;
        m_wdata   = ext_win ? e_wdata : core_win ? c_wdata : '0;
        e_gnt     = ext_win;
        c_stall   = core_req & (ext_win | ~c_w);
        e_rvalid  = (state == E_RD);
        c_rdata   = rd_done ? m_rdata : c_rdata_q;
        e_rdata   = e_rvalid ? m_rdata : e_rdata_q;
        state_nx  = (ext_win & ~e_we) ? E_RD : (core_win & ~c_w) ? C_RD : IDLE;
        starve_nx = ext_win ? 4'd0 : (core_win & ext_req & (starve_cnt != LIMIT)) ? starve_cnt + 4'd1 : starve_cnt;
    end
    // State, starvation counter and held read data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            c_rdata_q  <= '0;
            e_rdata_q  <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (rd_done) c_rdata_q <= m_rdata;
            if (e_rvalid) e_rdata_q <= m_rdata;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    // Count decision cycles where both requesters compete, saturating
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) conflict_cnt <= '0;
        else if (core_req & ext_req & (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a requester-level model.
module tb_dmem_arbiter;
    localparam int AW = 10, DW = 32, LIMIT = 4;
    logic CLK = 1'b0;
    logic RST;
    logic c_r, c_w, c_stall, e_req, e_we, e_gnt, e_rvalid, m_en, m_we;
    logic [AW-1:0] c_addr, e_addr, m_addr;
    logic [DW-1:0] c_wdata, c_rdata, e_wdata, e_rdata, m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif
    int checks = 0, errors = 0;
    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] gold [0:(1<<AW)-1];
    int c_kind, starve, nconf, gnt_at;
    bit c_both, e_pend, e_w, cw, ew, c_done, e_done, rand_mode;
    logic [AW-1:0] c_a, e_a;
    logic [DW-1:0] c_d, e_d, cexp, eexp, va, vb;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .c_r(c_r), .c_w(c_w), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_stall(c_stall),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_gnt(e_gnt),
        .e_rdata(e_rdata), .e_rvalid(e_rvalid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM seen by the arbiter
    always @(posedge CLK) begin
        if (m_en & m_we) mem[m_addr] <= m_wdata;
        if (m_en & ~m_we) m_rdata <= mem[m_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        c_r = (c_kind == 1) || (c_kind == 2 && c_both);
        c_w = (c_kind == 2);
        c_addr = c_a;
        c_wdata = c_d;
        e_req = e_pend;
        e_we = e_w;
        e_addr = e_a;
        e_wdata = e_d;
    endtask

    task automatic model_reset();
        starve = 0; nconf = 0; cw = 0; ew = 0; c_kind = 0; e_pend = 0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r = $urandom_range(0, 8);
        return (r == 8) ? 10'h3FF : 10'(r);
    endfunction

    // One clock: core and ext agents present their requests, the model decides who owns the RAM
    task automatic step();
        bit cw_now, force_e, eg, cg, exp_we;
        @(negedge CLK);
        drive();
        #1;
        cw_now = (c_kind != 0) && !cw;
        force_e = e_pend && (starve >= LIMIT);
        eg = e_pend && (force_e || !cw_now);
        cg = cw_now && !eg;
        exp_we = eg ? e_w : (cg && c_kind == 2);
        check("m_en", 32'(m_en), 32'(eg || cg));
        check("m_we", 32'(m_we), 32'(exp_we));
        check("c_stall", 32'(c_stall), 32'(cw_now && (eg || c_kind == 1)));
        check("e_gnt", 32'(e_gnt), 32'(eg));
        check("e_rvalid", 32'(e_rvalid), 32'(ew));
        if (eg || cg) check("m_addr", 32'(m_addr), 32'(eg ? e_a : c_a));
        if (exp_we) check("m_wdata", m_wdata, eg ? e_d : c_d);
        if (ew) check("e_rdata", e_rdata, eexp);
        if (cw) check("c_rdata", c_rdata, cexp);
        if (cw_now && e_pend && nconf < 65535) nconf++;
        c_done = cw; e_done = eg; cw = 0; ew = 0;
        if (cg) begin
            if (c_kind == 2) begin gold[c_a] = c_d; c_done = 1; end
            else begin cexp = gold[c_a]; cw = 1; end
        end
        if (eg) begin
            if (e_w) gold[e_a] = e_d;
            else begin eexp = gold[e_a]; ew = 1; end
            e_pend = 0;
            starve = 0;
        end else if (cg && e_pend && starve < LIMIT) starve++;
        if (c_done) c_kind = 0;
        if (rand_mode) begin
            if (c_kind == 0 && $urandom_range(0, 3) != 0) begin
                c_kind = $urandom_range(1, 2); c_both = 1'($urandom_range(0, 1));
                c_a = pick_addr(); c_d = $urandom;
            end
            if (!e_pend && $urandom_range(0, 2) == 0) begin
                e_pend = 1; e_w = 1'($urandom_range(0, 1)); e_a = pick_addr(); e_d = $urandom;
            end
        end
    endtask

    initial begin
        rand_mode = 0; c_both = 0; e_w = 0; c_a = '0; e_a = '0; c_d = '0; e_d = '0;
        model_reset();
        drive();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_m_en", 32'(m_en), 0);
        check("rst_c_stall", 32'(c_stall), 0);
        check("rst_e_gnt", 32'(e_gnt), 0);
        check("rst_e_rvalid", 32'(e_rvalid), 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_e_rdata", e_rdata, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c_kind = 2; c_both = 0; c_a = (i == 8) ? 10'h3FF : 10'(i); c_d = $urandom;
            step();
        end
        // Reset asserted during the ext read data cycle
        e_pend = 1; e_w = 0; e_a = 10'h003;
        step();
        c_kind = 1; c_a = 10'h002;
        @(negedge CLK);
        drive();
        RST = 1'b1;
        #1;
        check("rstmid_e_rvalid", 32'(e_rvalid), 0);
        check("rstmid_c_stall", 32'(c_stall), 0);
        check("rstmid_m_en", 32'(m_en), 0);
        check("rstmid_m_we", 32'(m_we), 0);
        check("rstmid_m_addr", 32'(m_addr), 0);
        check("rstmid_m_wdata", m_wdata, 0);
        check("rstmid_e_gnt", 32'(e_gnt), 0);
        model_reset();
        drive();
        @(negedge CLK);
        RST = 1'b0;
        // Core write then read of the same word
        c_kind = 2; c_both = 1; c_a = 10'h005; c_d = 32'hDEADBEEF;
        step();
        check("cw_m_we", 32'(m_we), 1);
        c_kind = 1; c_a = 10'h005;
        step();
        check("cr_issue_stall", 32'(c_stall), 1);
        step();
        check("cr_data_stall", 32'(c_stall), 0);
        check("cr_c_rdata", c_rdata, 32'hDEADBEEF);
        step();
        check("cr_c_rdata_hold", c_rdata, 32'hDEADBEEF);
        // Ext write then read at the top address
        e_pend = 1; e_w = 1; e_a = 10'h3FF; e_d = 32'h12345678;
        step();
        check("ew_gnt", 32'(e_done), 1);
        e_pend = 1; e_w = 0; e_a = 10'h3FF;
        step();
        step();
        check("er_rvalid", 32'(e_rvalid), 1);
        check("er_rdata", e_rdata, 32'h12345678);
        // Held ext request against a core writing every cycle
        e_pend = 1; e_w = 1; e_a = 10'h100; e_d = 32'hA5A50001; gnt_at = 0;
        for (int n = 1; n <= 6; n++) begin
            if (c_kind == 0) begin c_kind = 2; c_both = 0; c_a = 10'(n); c_d = $urandom; end
            step();
            if (e_done) gnt_at = n;
            if (n == 5) check("starve_denied_stall", 32'(c_stall), 1);
            if (n == 6) check("starve_retry_done", 32'(c_done), 1);
        end
        check("starve_gnt_cycle", 32'(gnt_at), 5);
        // Simultaneous core read and ext read
        va = $urandom; vb = $urandom;
        c_kind = 2; c_a = 10'h010; c_d = va;
        step();
        e_pend = 1; e_w = 1; e_a = 10'h020; e_d = vb;
        step();
        c_kind = 1; c_both = 0; c_a = 10'h010;
        e_pend = 1; e_w = 0; e_a = 10'h020;
        step();
        check("sim_issue_stall", 32'(c_stall), 1);
        check("sim_issue_no_egnt", 32'(e_gnt), 0);
        step();
        check("sim_crd_egnt", 32'(e_gnt), 1);
        check("sim_c_rdata", c_rdata, va);
        step();
        check("sim_e_rvalid", 32'(e_rvalid), 1);
        check("sim_e_rdata", e_rdata, vb);
        // Randomized traffic from both requesters
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 0;
        c_kind = 0; e_pend = 0;
        repeat (3) step();
`ifdef DMEM_ARB_STATS_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(nconf));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
